uart_tx_engine: RTL
===================

Name: uart_tx_engine

Overview:
Parametrised, runtime-configurable UART transmitter with an integrated TX FIFO. It is the next generation of the TX half of uart_protocol. It adds programmable data length (5..DATA_SIZE), parity mode (none/even/odd), 1 or 2 stop bits, a programmable baud divisor and a transmit enable. It sits between the bus write interface and serial_data_out. The bus side uses the same write_data / bus_data_in / TX_status_register convention as uart_protocol.

Parameters:
DATA_SIZE, 8, maximum data bits per frame; also the FIFO word width.
SIZE_FIFO, 8, TX FIFO depth in words; must be a power of 2, at least 2.
DVSR_W, 16, width of baud_dvsr.
CNT_W, $clog2(SIZE_FIFO+1), width of fifo_count.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
tx_enable  input  1  allow new frames to start.
baud_dvsr  input  DVSR_W  clocks per bit minus 1.
data_len  input  4  data bits per frame; values below 5 are clamped to 5, values above DATA_SIZE to DATA_SIZE.
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
stop2  input  1  0: one stop bit, 1: two stop bits.
write_data  input  1  push bus_data_in into the FIFO.
bus_data_in  input  DATA_SIZE  byte to transmit.
clear_error  input  1  clears error_write_data.
serial_data_out  output  1  serial line, idle high.
tx_busy  output  1  a frame is in progress.
fifo_count  output  CNT_W  number of words held in the FIFO.
TX_status_register  output  8  {4'b0, tx_busy, empty, full, error_write_data}.

Behaviour:
- Reset (async assert):
  - serial_data_out=1, tx_busy=0, fifo_count=0, empty=1, full=0, error_write_data=0.
  - FIFO is flushed and the FSM goes to IDLE.
  - Applies mid-frame: the line returns high immediately; no partial-frame completion.
- FIFO:
  - A write while not full is accepted.
  - A write while full is dropped and sets error_write_data (sticky).
  - A simultaneous pop and write while full is accepted; count is unchanged.
  - clear_error clears the flag. If a dropped write occurs in the same cycle as clear_error, the set wins.
  - Pointers wrap modulo SIZE_FIFO. Status bits are registered and reflect the post-edge count.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: line=1. If tx_enable and !empty: pop the head word, latch the word plus data_len/parity_mode/stop2/baud_dvsr into frame registers, go to START.
  - START: line=0 for baud_dvsr+1 clocks.
  - DATA: send latched data_len bits LSB first, each baud_dvsr+1 clocks.
  - PARITY: entered only if the latched mode is even/odd.
    - Even: bit = XOR of the sent data bits.
    - Odd: the inverse of that.
  - STOP: line=1 for (stop2?2:1)*(baud_dvsr+1) clocks. At the last stop clock: if tx_enable and !empty, pop and go to START directly (no idle gap); otherwise go to IDLE.
- Configuration inputs are sampled only at frame start. Changes mid-frame take effect from the next frame.
- Deasserting tx_enable mid-frame: the current frame completes, and no new frame starts.
- Latency: write_data accepted at edge N with the FSM in IDLE and FIFO empty:
  - empty=0 after N.
  - The pop plus START entry occur at N+1, so serial_data_out=0 from edge N+1.
  - fifo_count returns to 0 after N+1.
- tx_busy=1 in every state except IDLE.
- A single bit counter (DVSR_W) and a data-bit index counter (4 bits) are used. baud_dvsr=0 gives 1 clock per bit.

Decomposition:
- uart_pkg holds:
  - typedef enum tx_state_e {IDLE, START, DATA, PARITY, STOP}.
  - typedef enum parity_mode_e {PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2}.
  - Status bit index constants ST_ERR=0, ST_FULL=1, ST_EMPTY=2, ST_BUSY=3.
- Sub-module uart_sync_fifo (WIDTH, DEPTH): push/pop/count/full/empty plus the sticky overflow flag. The FSM, baud counter and parity logic live in uart_tx_engine.

Test Plan:
1. 8N1, baud_dvsr=3, write 0xA5 → line 0 for 4 clks, then bits 1,0,1,0,0,1,0,1 (4 clks each), then 1 for 4 clks. Total frame 40 clks; tx_busy falls at frame end.
2. data_len=7, even, stop2=1, dvsr=3, write 0xB5 → data bits 1,0,1,0,1,1,0 (bit7 not sent), parity 0, then 8 clks high. Frame 44 clks.
3. data_len=5, odd, dvsr=1, write 0xFF → data bits 11111, parity 0; data_len=3 → clamped to 5, same result.
4. tx_enable=0, write 9 bytes 0x01..0x09 → full=1 after the 8th, 0x09 dropped, error_write_data=1, fifo_count=8. Then clear_error → 0. Then tx_enable=1 → 8 frames 0x01..0x08 back-to-back with zero idle clocks between stop and start.
5. Mid-frame (during DATA of 0x3C) assert reset for 1 clk → serial_data_out=1 immediately, empty=1, fifo_count=0, tx_busy=0. No further frames after release.
6. During frame 1 (8N1) change data_len=6, parity even, and write a second byte → frame 1 unchanged; frame 2 uses 6 data bits plus parity.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and status-bit indices for the UART TX engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  localparam int ST_ERR   = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_BUSY  = 3;

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ============================================================================
// Module   : uart_sync_fifo
// Brief    : Synchronous FIFO with registered status and sticky overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_err
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic             r_full, r_empty, r_err;
  logic             w_do_push, w_do_pop, w_ovf;

  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign w_do_pop  = i_pop && !r_empty;
  assign w_do_push = i_push && (!r_full || w_do_pop);
  assign w_ovf     = i_push && r_full && !w_do_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop)
      w_count_nxt = r_count + 1'b1;
    else if (!w_do_push && w_do_pop)
      w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (w_ovf)
        r_err <= 1'b1;
      else if (i_clr_err)
        r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_err   = r_err;

endmodule

`default_nettype wire

// File: rtl/uart_tx_engine.sv
// ============================================================================
// Module   : uart_tx_engine
// Brief    : Configurable UART transmitter (5..DATA_SIZE bits, parity, 1/2 stop)
//            fed by an internal TX FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int SIZE_FIFO = 8,
  parameter int DVSR_W    = 16,
  parameter int CNT_W     = $clog2(SIZE_FIFO + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_enable,
  input  logic [DVSR_W-1:0]    baud_dvsr,
  input  logic [3:0]           data_len,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 write_data,
  input  logic [DATA_SIZE-1:0] bus_data_in,
  input  logic                 clear_error,
  output logic                 serial_data_out,
  output logic                 tx_busy,
  output logic [CNT_W-1:0]     fifo_count,
  output logic [7:0]           TX_status_register
);

  localparam logic [3:0] c_MIN_LEN = 4'd5;
  localparam logic [3:0] c_MAX_LEN = 4'(DATA_SIZE);

  tx_state_e              r_state, w_state_nxt;
  logic [DVSR_W-1:0]      r_baud_cnt, w_baud_nxt, r_dvsr;
  logic [3:0]             r_bit_idx, w_idx_nxt, r_len, w_len_clamp, w_last_idx;
  logic [DATA_SIZE-1:0]   r_data, w_head, w_data_shift;
  logic                   r_par_en, r_par_odd, r_stop2;
  logic                   w_full, w_empty, w_err, w_pop;
  logic                   w_tick, w_can_start, w_par_bit, w_line;

  uart_sync_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (SIZE_FIFO),
    .CW    (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .i_push    (write_data),
    .i_pop     (w_pop),
    .i_din     (bus_data_in),
    .i_clr_err (clear_error),
    .o_head    (w_head),
    .o_count   (fifo_count),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_err     (w_err)
  );

  always_comb begin
    w_len_clamp = data_len;
    if (data_len < c_MIN_LEN)
      w_len_clamp = c_MIN_LEN;
    else if (data_len > c_MAX_LEN)
      w_len_clamp = c_MAX_LEN;
  end

  assign w_tick       = (r_baud_cnt == r_dvsr);
  assign w_can_start  = tx_enable && !w_empty;
  assign w_last_idx   = r_len - 4'd1;
  assign w_data_shift = r_data >> r_bit_idx;

  // Parity covers only the bits actually sent on the line.
  always_comb begin
    w_par_bit = r_par_odd;
    for (int i = 0; i < DATA_SIZE; i++)
      if (i < int'(r_len)) w_par_bit = w_par_bit ^ r_data[i];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_tick ? '0 : r_baud_cnt + 1'b1;
    w_idx_nxt   = r_bit_idx;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        if (w_can_start) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
          w_idx_nxt   = '0;
        end
      end
      START: if (w_tick) begin
        w_state_nxt = DATA;
        w_idx_nxt   = '0;
      end
      DATA: if (w_tick) begin
        if (r_bit_idx == w_last_idx) begin
          w_idx_nxt   = '0;
          w_state_nxt = r_par_en ? PARITY : STOP;
        end else begin
          w_idx_nxt = r_bit_idx + 4'd1;
        end
      end
      PARITY: if (w_tick) begin
        w_state_nxt = STOP;
        w_idx_nxt   = '0;
      end
      STOP: if (w_tick) begin
        // bit index doubles as the stop-bit counter for two-stop frames
        if (r_stop2 && (r_bit_idx == 4'd0)) begin
          w_idx_nxt = 4'd1;
        end else if (w_can_start) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_data     <= '0;
      r_len      <= c_MIN_LEN;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_stop2    <= 1'b0;
      r_dvsr     <= '0;
    end else begin
      r_baud_cnt <= w_baud_nxt;
      r_bit_idx  <= w_idx_nxt;
      if (w_pop) begin
        r_data    <= w_head;
        r_len     <= w_len_clamp;
        r_par_en  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
        r_par_odd <= (parity_mode == PAR_ODD);
        r_stop2   <= stop2;
        r_dvsr    <= baud_dvsr;
      end
    end
  end

  always_comb begin
    case (r_state)
      START:   w_line = 1'b0;
      DATA:    w_line = w_data_shift[0];
      PARITY:  w_line = w_par_bit;
      default: w_line = 1'b1;
    endcase
  end

  assign serial_data_out = w_line;
  assign tx_busy         = (r_state != IDLE);

  always_comb begin
    TX_status_register           = '0;
    TX_status_register[ST_ERR]   = w_err;
    TX_status_register[ST_FULL]  = w_full;
    TX_status_register[ST_EMPTY] = w_empty;
    TX_status_register[ST_BUSY]  = tx_busy;
  end

endmodule

`default_nettype wire
